// File: rtl/vstore_pack_buffer.sv
// vstore_pack_buffer
// Packs one SEW8/16/32 element per lane per beat into 32-bit lane words with
// byte strobes, buffers complete rows in a DEPTH-row FIFO and drains each row
// lane 0..V_LANE_NUM-1 onto a backpressured write stream with tstrb and tlast.
module vstore_pack_buffer #(
    parameter int V_LANE_NUM = 8,
    parameter int DEPTH      = 16,
    parameter int LEN_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                cfg_sew,
    input  logic [LEN_W-1:0]          cfg_len,
    output logic                      busy,
    output logic                      done,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [32*V_LANE_NUM-1:0]  in_data,
    output logic                      axi_wr_tvalid,
    input  logic                      axi_wr_tready,
    output logic [31:0]               axi_wr_tdata,
    output logic [3:0]                axi_wr_tstrb,
    output logic                      axi_wr_tlast
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (V_LANE_NUM > 1) ? $clog2(V_LANE_NUM) : 1;
    localparam int ROW_DW = 32 * V_LANE_NUM;
    localparam int ROW_SW = 4 * V_LANE_NUM;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(V_LANE_NUM - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sew_q, sew_d;          // 0=SEW8, 1=SEW16, 2=SEW32
    logic [LEN_W-1:0]    remain_q, remain_d;    // elements per lane still to accept
    logic [LEN_W-1:0]    rows_left_q, rows_left_d; // rows still to drain
    logic [1:0]          k_q, k_d;              // pack index inside the current row
    logic [ROW_DW-1:0]   pack_data_q, pack_data_d;
    logic [ROW_SW-1:0]   pack_strb_q, pack_strb_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [LANE_W-1:0]   lane_sel_q, lane_sel_d;
    logic                done_q, done_d;

    // Row storage; data and strobes live side by side at the same address.
    logic [ROW_DW-1:0]   mem_data [DEPTH];
    logic [ROW_SW-1:0]   mem_strb [DEPTH];

    logic [ROW_DW-1:0]   beat_data;
    logic [ROW_SW-1:0]   beat_strb;
    logic [ROW_DW-1:0]   head_data;
    logic [ROW_SW-1:0]   head_strb;
    logic [1:0]          sew_cfg;
    logic [LEN_W-1:0]    rows_cfg;
    logic                accept;
    logic                last_k;
    logic                commit;
    logic                pop_word;
    logic                pop_row;
    logic                fifo_nonempty;

    // Per-lane merge of the incoming element into the partially packed word.
    for (genvar gi = 0; gi < V_LANE_NUM; gi++) begin : g_lane
        logic [31:0] elem;
        logic [31:0] lane_data;
        logic [3:0]  lane_strb;

        assign elem = in_data[32*gi +: 32];

        // Place the element at byte offset k*SEW/8 and set its strobes.
        always_comb begin
            lane_data = pack_data_q[32*gi +: 32];
            lane_strb = pack_strb_q[4*gi +: 4];
            case (sew_q)
                2'd0: begin
                    lane_data[{k_q, 3'b000} +: 8] = elem[7:0];
                    lane_strb[k_q]                = 1'b1;
                end
                2'd1: begin
                    lane_data[{k_q[0], 4'b0000} +: 16] = elem[15:0];
                    lane_strb[{k_q[0], 1'b0} +: 2]     = 2'b11;
                end
                default: begin
                    lane_data = elem;
                    lane_strb = 4'hF;
                end
            endcase
        end

        assign beat_data[32*gi +: 32] = lane_data;
        assign beat_strb[4*gi +: 4]   = lane_strb;
    end

    // SEW encodings 2 and 3 both mean 32-bit elements.
    assign sew_cfg = (cfg_sew == 2'd3) ? 2'd2 : cfg_sew;

    // Row count ceil(len/F) without widening the length.
    always_comb begin
        case (sew_cfg)
            2'd0:    rows_cfg = (cfg_len >> 2) + LEN_W'(|cfg_len[1:0]);
            2'd1:    rows_cfg = (cfg_len >> 1) + LEN_W'(cfg_len[0]);
            default: rows_cfg = cfg_len;
        endcase
    end

    // A row is complete when the last pack slot for this SEW is written.
    always_comb begin
        case (sew_q)
            2'd0:    last_k = (k_q == 2'd3);
            2'd1:    last_k = (k_q == 2'd1);
            default: last_k = 1'b1;
        endcase
    end

    assign fifo_nonempty = (count_q != '0);
    // Full check uses the registered count only, so a same-cycle pop never
    // opens the input at full.
    assign in_ready  = (state_q == ST_RUN) && (remain_q != '0) && (count_q != FULL_CNT);
    assign accept    = in_valid && in_ready;
    assign commit    = accept && (last_k || (remain_q == LEN_W'(1)));
    assign pop_word  = fifo_nonempty && axi_wr_tready;
    assign pop_row   = pop_word && (lane_sel_q == LAST_LANE);

    assign head_data = mem_data[rd_ptr_q];
    assign head_strb = mem_strb[rd_ptr_q];

    // Outputs are forced to zero whenever nothing is buffered.
    assign axi_wr_tvalid = fifo_nonempty;
    assign axi_wr_tdata  = fifo_nonempty ? head_data[32*lane_sel_q +: 32] : 32'h0;
    assign axi_wr_tstrb  = fifo_nonempty ? head_strb[4*lane_sel_q +: 4]   : 4'h0;
    assign axi_wr_tlast  = fifo_nonempty && (lane_sel_q == LAST_LANE) &&
                           (rows_left_q == LEN_W'(1));
    assign busy          = (state_q == ST_RUN);
    assign done          = done_q;

    // Next-state logic for the FSM, packer, FIFO pointers and drain counters.
    always_comb begin
        state_d     = state_q;
        sew_d       = sew_q;
        remain_d    = remain_q;
        rows_left_d = rows_left_q;
        k_d         = k_q;
        pack_data_d = pack_data_q;
        pack_strb_d = pack_strb_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        lane_sel_d  = lane_sel_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sew_d       = sew_cfg;
                    k_d         = 2'd0;
                    pack_data_d = '0;
                    pack_strb_d = '0;
                    lane_sel_d  = '0;
                    if (cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_RUN;
                        remain_d    = cfg_len;
                        rows_left_d = rows_cfg;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    remain_d = remain_q - LEN_W'(1);
                    if (commit) begin
                        k_d         = 2'd0;
                        pack_data_d = '0;
                        pack_strb_d = '0;
                        wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                    end else begin
                        k_d         = k_q + 2'd1;
                        pack_data_d = beat_data;
                        pack_strb_d = beat_strb;
                    end
                end
                if (pop_word) begin
                    lane_sel_d = (lane_sel_q == LAST_LANE) ? '0 : lane_sel_q + LANE_W'(1);
                    if (axi_wr_tlast) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                if (pop_row) begin
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                    rows_left_d = rows_left_q - LEN_W'(1);
                end
                case ({commit, pop_row})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and packing registers; reset discards any buffered rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sew_q       <= 2'd0;
            remain_q    <= '0;
            rows_left_q <= '0;
            k_q         <= 2'd0;
            pack_data_q <= '0;
            pack_strb_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            lane_sel_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sew_q       <= sew_d;
            remain_q    <= remain_d;
            rows_left_q <= rows_left_d;
            k_q         <= k_d;
            pack_data_q <= pack_data_d;
            pack_strb_q <= pack_strb_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            lane_sel_q  <= lane_sel_d;
            done_q      <= done_d;
        end
    end

    // Row write on the commit edge; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (commit) begin
            mem_data[wr_ptr_q] <= beat_data;
            mem_strb[wr_ptr_q] <= beat_strb;
        end
    end

endmodule
